// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl_if
// Description : Core-side and memory-side signal bundle of the L1 data cache.
// Revision    : 1.0  initial release
// ============================================================================
interface dcache_ctrl_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [2:0]  cpu_mask;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_mask;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;

   logic [15:0] miss_count;

   // Cache view.
   modport slave (
      input  cpu_addr, cpu_wdata, cpu_mask, cpu_rd_en, cpu_wr_en, mem_rdata,
      output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_mask,
      output mem_wr_en, mem_rd_en, miss_count
   );

   // Core plus memory view.
   modport master (
      output cpu_addr, cpu_wdata, cpu_mask, cpu_rd_en, cpu_wr_en, mem_rdata,
      input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_mask,
      input  mem_wr_en, mem_rd_en, miss_count
   );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate L1 data cache with
//               one-word lines, byte/halfword merge and load extension.
// Revision    : 1.0  initial release
// ============================================================================
module dcache_ctrl #(
   parameter int NUM_LINES = 16
) (
   input  wire logic    clk,
   input  wire logic    reset,
   dcache_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - IDX_W - 2;

   localparam logic [2:0] c_MASK_B  = 3'b000;
   localparam logic [2:0] c_MASK_H  = 3'b001;
   localparam logic [2:0] c_MASK_W  = 3'b010;
   localparam logic [2:0] c_MASK_BU = 3'b100;
   localparam logic [2:0] c_MASK_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_REFILL    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [31:0]          r_data [NUM_LINES];
   logic [15:0]          r_miss_count;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_req;
   logic             w_hit;
   logic             w_is_load;
   logic             w_victim_dirty;
   logic             w_store_ok;
   logic             w_store_wr;
   logic [31:0]      w_line;
   logic [31:0]      w_load_data;
   logic [31:0]      w_merged;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;

   assign w_idx          = bus.cpu_addr[IDX_W+1:2];
   assign w_tag          = bus.cpu_addr[31:IDX_W+2];
   assign w_req          = bus.cpu_rd_en | bus.cpu_wr_en;
   assign w_is_load      = bus.cpu_rd_en & ~bus.cpu_wr_en;
   assign w_line         = r_data[w_idx];
   assign w_hit          = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

   // Load path: pick byte/half by the low address bits, then extend.
   always_comb begin
      w_byte      = w_line[{bus.cpu_addr[1:0], 3'b000} +: 8];
      w_half      = bus.cpu_addr[1] ? w_line[31:16] : w_line[15:0];
      w_load_data = 32'h0;
      case (bus.cpu_mask)
         c_MASK_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
         c_MASK_H:  w_load_data = {{16{w_half[15]}}, w_half};
         c_MASK_W:  w_load_data = w_line;
         c_MASK_BU: w_load_data = {24'h0, w_byte};
         c_MASK_HU: w_load_data = {16'h0, w_half};
         default:   w_load_data = 32'h0;
      endcase
   end

   // Store path: merge the low byte/half of wdata into the resident word.
   always_comb begin
      w_merged   = w_line;
      w_store_ok = 1'b1;
      case (bus.cpu_mask)
         c_MASK_B: w_merged[{bus.cpu_addr[1:0], 3'b000} +: 8] = bus.cpu_wdata[7:0];
         c_MASK_H: begin
            if (bus.cpu_addr[1]) begin
               w_merged[31:16] = bus.cpu_wdata[15:0];
            end else begin
               w_merged[15:0]  = bus.cpu_wdata[15:0];
            end
         end
         c_MASK_W: w_merged = bus.cpu_wdata;
         default:  w_store_ok = 1'b0;
      endcase
   end

   assign w_store_wr = (r_state == ST_IDLE) & bus.cpu_wr_en & w_hit & w_store_ok;

   always_comb begin
      w_next_state  = r_state;
      bus.mem_wr_en = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      case (r_state)
         ST_IDLE: begin
            if (w_req && !w_hit) begin
               w_next_state = w_victim_dirty ? ST_WRITEBACK : ST_REFILL;
            end
         end
         ST_WRITEBACK: begin
            w_next_state  = ST_REFILL;
            bus.mem_wr_en = 1'b1;
            bus.mem_addr  = {r_tag[w_idx], w_idx, 2'b00};
            bus.mem_wdata = w_line;
         end
         ST_REFILL: begin
            w_next_state  = ST_IDLE;
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = {w_tag, w_idx, 2'b00};
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign bus.cpu_stall  = (r_state != ST_IDLE) | (w_req & ~w_hit);
   assign bus.cpu_rdata  = ((r_state == ST_IDLE) && w_is_load && w_hit) ? w_load_data : 32'h0;
   assign bus.mem_mask   = c_MASK_W;
   assign bus.miss_count = r_miss_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_miss_count <= 16'h0;
         r_valid      <= '0;
         r_dirty      <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == ST_IDLE) && (w_next_state != ST_IDLE)) begin
            r_miss_count <= r_miss_count + 16'd1;
         end
         if (r_state == ST_REFILL) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
         end else if (w_store_wr) begin
            r_dirty[w_idx] <= 1'b1;
         end
      end
   end

   // Tag and data contents need no reset: valid gates every use of them.
   always_ff @(posedge clk) begin
      if (r_state == ST_REFILL) begin
         r_tag[w_idx]  <= w_tag;
         r_data[w_idx] <= bus.mem_rdata;
      end else if (w_store_wr) begin
         r_data[w_idx] <= w_merged;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Scoreboard bench for dcache_ctrl with a word memory model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic reset;

   dcache_ctrl_if bus();

   dcache_ctrl #(.NUM_LINES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_op_t;

   logic [31:0] load_q [$];
   mem_op_t     mem_q  [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] mem_words [256];

   assign bus.mem_rdata = bus.mem_rd_en ? mem_words[bus.mem_addr[9:2]] : 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s", name);
   endtask

   // Word memory; absorbs writebacks during the strobe cycle.
   initial begin
      for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
      mem_words[8'h10] = 32'hDEADBEEF;   // 0x40
      mem_words[8'h20] = 32'hCAFEF00D;   // 0x80
      forever begin
         @(negedge clk);
         if (bus.mem_wr_en) mem_words[bus.mem_addr[9:2]] = bus.mem_wdata;
      end
   end

   // Monitor: compare every memory transfer and every completed load.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_wr_en || bus.mem_rd_en) begin
            if (mem_q.size() == 0) begin
               fail_now("mem_unexpected_transfer");
            end else begin
               mem_op_t op;
               op = mem_q.pop_front();
               check("mem_wr_en", {31'h0, bus.mem_wr_en}, {31'h0, op.wr});
               check("mem_rd_en", {31'h0, bus.mem_rd_en}, {31'h0, ~op.wr});
               check("mem_addr",  bus.mem_addr,  op.addr);
               check("mem_wdata", bus.mem_wdata, op.wdata);
               check("mem_mask",  {29'h0, bus.mem_mask}, 32'h2);
            end
         end else begin
            check("idle_mem_addr",  bus.mem_addr,  32'h0);
            check("idle_mem_wdata", bus.mem_wdata, 32'h0);
         end
         if (bus.cpu_rd_en && !bus.cpu_stall) begin
            if (load_q.size() == 0) fail_now("load_unexpected");
            else check("cpu_rdata", bus.cpu_rdata, load_q.pop_front());
         end else begin
            check("rdata_zero", bus.cpu_rdata, 32'h0);
         end
      end
   end

   task automatic do_req(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] mask, input int exp_stall);
      int stalls = 0;
      bit done   = 1'b0;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.cpu_mask  = mask;
      bus.cpu_rd_en = rd;
      bus.cpu_wr_en = wr;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!bus.cpu_stall) done = 1'b1;
         else stalls++;
      end
      if (!done) fail_now({name, "_timeout"});
      check({name, "_stalls"}, stalls, exp_stall);
      @(posedge clk);
      #1;
      bus.cpu_rd_en = 1'b0;
      bus.cpu_wr_en = 1'b0;
   endtask

   task automatic exp_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      mem_op_t op;
      op.wr    = wr;
      op.addr  = addr;
      op.wdata = wdata;
      mem_q.push_back(op);
   endtask

   task automatic ld(input string name, input logic [31:0] addr, input logic [2:0] mask,
                     input logic [31:0] exp, input int stall);
      load_q.push_back(exp);
      do_req(name, 1'b1, 1'b0, addr, 32'h0, mask, stall);
   endtask

   task automatic st(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] mask, input int stall);
      do_req(name, 1'b0, 1'b1, addr, wdata, mask, stall);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      bool_init();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_stall",      {31'h0, bus.cpu_stall}, 32'h0);
      check("rst_miss_count", {16'h0, bus.miss_count}, 32'h0);
      check("rst_mem_wr_en",  {31'h0, bus.mem_wr_en}, 32'h0);
      check("rst_mem_rd_en",  {31'h0, bus.mem_rd_en}, 32'h0);
      @(posedge clk);
      #1;

      // Clean miss then hit.
      exp_mem(1'b0, 32'h40, 32'h0);
      ld("lw40_miss", 32'h40, 3'b010, 32'hDEADBEEF, 2);
      check("miss_count_1", {16'h0, bus.miss_count}, 32'd1);

      // Store merge and load extension on a resident line.
      st("sw40", 32'h40, 32'h11223344, 3'b010, 0);
      st("sb41", 32'h41, 32'h000000A5, 3'b000, 0);
      ld("lw40",  32'h40, 3'b010, 32'h1122A544, 0);
      ld("lbu41", 32'h41, 3'b100, 32'h000000A5, 0);
      ld("lb41",  32'h41, 3'b000, 32'hFFFFFFA5, 0);
      ld("lhu42", 32'h42, 3'b101, 32'h00001122, 0);
      ld("lh40",  32'h40, 3'b001, 32'hFFFFA544, 0);
      ld("lb43",  32'h43, 3'b000, 32'h00000011, 0);

      // Dirty eviction by same-index different-tag load.
      exp_mem(1'b1, 32'h40, 32'h1122A544);
      exp_mem(1'b0, 32'h80, 32'h0);
      ld("lw80_dirty", 32'h80, 3'b010, 32'hCAFEF00D, 3);
      check("miss_count_2", {16'h0, bus.miss_count}, 32'd2);
      exp_mem(1'b0, 32'h40, 32'h0);
      ld("lw40_back", 32'h40, 3'b010, 32'h1122A544, 2);

      // Store miss allocates, then merges and dirties the line.
      exp_mem(1'b0, 32'h100, 32'h0);
      st("sh102_miss", 32'h102, 32'h0000BEEF, 3'b001, 2);
      ld("lw100", 32'h100, 3'b010, 32'hBEEF0000, 0);
      exp_mem(1'b1, 32'h100, 32'hBEEF0000);
      exp_mem(1'b0, 32'h140, 32'h0);
      ld("lw140_dirty", 32'h140, 3'b010, 32'h0, 3);
      check("miss_count_5", {16'h0, bus.miss_count}, 32'd5);

      // Reset in the middle of a writeback.
      exp_mem(1'b0, 32'h0C, 32'h0);
      st("sw0c_miss", 32'h0C, 32'h00000055, 3'b010, 2);
      exp_mem(1'b1, 32'h0C, 32'h00000055);
      bus.cpu_addr  = 32'h4C;
      bus.cpu_mask  = 3'b010;
      bus.cpu_rd_en = 1'b1;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en) seen = 1'b1;
         end
         if (!seen) fail_now("wb_never_started");
      end
      #1;
      reset         = 1'b1;
      bus.cpu_rd_en = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_mem_wr_en",  {31'h0, bus.mem_wr_en}, 32'h0);
      check("abort_stall",      {31'h0, bus.cpu_stall}, 32'h0);
      check("abort_miss_count", {16'h0, bus.miss_count}, 32'h0);
      @(posedge clk);
      #1;
      exp_mem(1'b0, 32'h40, 32'h0);
      ld("lw40_after_rst", 32'h40, 3'b010, 32'h1122A544, 2);
      check("miss_count_r1", {16'h0, bus.miss_count}, 32'd1);

      // Read and write together: store wins, load data is zero.
      load_q.push_back(32'h0);
      do_req("rdwr40", 1'b1, 1'b1, 32'h40, 32'h12345678, 3'b010, 0);
      ld("lw40_rdwr", 32'h40, 3'b010, 32'h12345678, 0);
      ld("lbad40",    32'h40, 3'b011, 32'h0, 0);

      // Unsupported store mask must neither write nor dirty.
      exp_mem(1'b1, 32'h40, 32'h12345678);
      exp_mem(1'b0, 32'h80, 32'h0);
      ld("lw80_evict", 32'h80, 3'b010, 32'hCAFEF00D, 3);
      st("sbad80", 32'h80, 32'hFFFFFFFF, 3'b011, 0);
      ld("lw80_keep", 32'h80, 3'b010, 32'hCAFEF00D, 0);
      exp_mem(1'b0, 32'h40, 32'h0);
      ld("lw40_clean", 32'h40, 3'b010, 32'h12345678, 2);
      check("miss_count_r3", {16'h0, bus.miss_count}, 32'd3);

      repeat (3) @(negedge clk);
      check("load_q_drained", load_q.size(), 32'h0);
      check("mem_q_drained",  mem_q.size(),  32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   task automatic bool_init();
      bus.cpu_addr  = 32'h0;
      bus.cpu_wdata = 32'h0;
      bus.cpu_mask  = 3'b010;
      bus.cpu_rd_en = 1'b0;
      bus.cpu_wr_en = 1'b0;
   endtask
endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller placed between the core's load/store stage and the word-addressed data memory. It serves loads and stores from a local array of one-word lines. It merges byte/halfword stores and sign/zero-extends loads using the same mask encoding as the memory. On a miss it stalls the core, writes back a dirty victim if needed, and refills from memory using word-wide transfers only.

## Interface
- NUM_LINES, 16: number of one-word lines; power of two, ≥2. IDX_W = log2(NUM_LINES).
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  32  byte address; index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
- cpu_wdata  in  32  store data (low byte/halfword used for sb/sh).
- cpu_mask  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- cpu_rd_en  in  1  load request.
- cpu_wr_en  in  1  store request.
- cpu_rdata  out  32  load result, valid when a load is requested and cpu_stall=0.
- cpu_stall  out  1  core must hold all cpu_* inputs stable while high.
- mem_addr  out  32  word-aligned memory address (bits[1:0]=00).
- mem_wdata  out  32  victim word for writeback.
- mem_mask  out  3  always 3'b010.
- mem_wr_en  out  1  writeback strobe.
- mem_rd_en  out  1  refill strobe.
- mem_rdata  in  32  memory read data, combinational from mem_addr when mem_rd_en=1.
- miss_count  out  16  count of misses since reset; wraps 0xFFFF→0.

## Operation
- Per line: valid, dirty, tag, 32-bit data. Reset clears all valid and dirty; data and tag contents are don't-care.
- Request = cpu_rd_en | cpu_wr_en. If both are high, the request is a store and the load is ignored (cpu_rdata = 0).
- Hit = valid[idx] & (tag[idx] == req tag).
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE, no request or hit: stay in IDLE.
  - IDLE, miss with dirty victim: go to WRITEBACK. Otherwise go to REFILL.
  - WRITEBACK: go to REFILL.
  - REFILL: go to IDLE.
- miss_count increments on each IDLE→(WRITEBACK|REFILL) transition.
- Load hit: cpu_rdata is the byte/halfword/word selected by addr[1:0]/addr[1] and extended per mask. An unsupported mask returns 0.
- Store hit: at the posedge, merge wdata into the line (sb into byte addr[1:0], sh into half addr[1], sw whole word) and set dirty. An unsupported mask leaves data and dirty unchanged.
- WRITEBACK: mem_wr_en=1, mem_addr={victim tag, idx, 2'b00}, mem_wdata = victim data.
- REFILL: mem_rd_en=1, mem_addr={req tag, idx, 2'b00}. At the posedge the line takes mem_rdata, valid=1, dirty=0, tag=req tag.
- After REFILL the held request hits in IDLE. Stores therefore allocate first, then merge.
- Outputs when idle: mem_wr_en, mem_rd_en, mem_addr, mem_wdata and cpu_rdata are 0 whenever the controller is not driving them.

## Timing
- Reset values: state IDLE, miss_count 0, mem_wr_en 0, mem_rd_en 0, mem_addr 0, mem_wdata 0, cpu_rdata 0. cpu_stall is 0 unless a request is present.
- cpu_stall = (state≠IDLE) | (request & ~hit), combinational.
- Hit: zero stall cycles. Load data is valid in the same cycle; store data is written at that cycle's posedge.
- Clean miss: 2 stall cycles (IDLE-miss, REFILL); data returns in the 3rd cycle.
- Dirty miss: 3 stall cycles (IDLE-miss, WRITEBACK, REFILL).
- Each memory strobe is high for exactly one cycle per transfer.
- Reset asserted in any state: next cycle is IDLE, all lines invalid, miss_count 0. An in-flight writeback is abandoned and the dirty data is lost.
- Back-to-back requests to the same index with different tags each take a full miss sequence. No state leaks between requests.

## Test plan
- Reset, then lw 0x40 with memory[0x40]=0xDEADBEEF: stall for 2 cycles, mem_rd_en=1 with mem_addr=0x40 in REFILL, then cpu_rdata=0xDEADBEEF with stall=0, miss_count=1.
- Line 0x40 holds 0x11223344; sb 0xA5 to 0x41: no stall. Then lw 0x40 → 0x1122A544, lbu 0x41 → 0x000000A5, lb 0x41 → 0xFFFFFFA5, lhu 0x42 → 0x00001122.
- Dirty line 0x40 (0x1122A544), then lw 0x80 (same index 0): WRITEBACK drives mem_wr_en=1, mem_addr=0x40, mem_wdata=0x1122A544, mem_mask=010 for one cycle. REFILL follows with mem_addr=0x80. Stall lasts 3 cycles; miss_count increments by 1.
- sh 0xBEEF to 0x102 (clean miss, memory word 0x00000000): refill, then merge. A later lw 0x100 returns 0xBEEF0000 and the line is dirty, so evicting it with lw 0x140 writes back 0xBEEF0000.
- Assert reset during WRITEBACK: next cycle mem_wr_en=0, state IDLE, miss_count=0. Then lw 0x40 misses again (stall for 2 cycles).
- cpu_rd_en=cpu_wr_en=1, sw 0x12345678 to hit 0x40: cpu_rdata=0 and the line becomes 0x12345678, dirty. A store with mask 011 to a hit line leaves data unchanged and does not set dirty.
